// File: rtl/cache_ctrl.sv
// Controller for one direct-mapped cache set: sequences hit, dirty write-back
// and refill, and bridges to a word-wide memory port.
module cache_ctrl #(
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned SET_WIDTH    = 8,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic                    cpu_ready_o,
  output logic [31:0]             cpu_rdata_o,
  input  logic                    line_hit_i,
  input  logic                    line_valid_i,
  input  logic                    line_dirty_i,
  input  logic [TAG_WIDTH-1:0]    line_tag_i,
  input  logic [31:0]             line_rdata_i,
  output logic                    line_write_en_o,
  output logic                    line_update_en_o,
  output logic                    line_set_valid_o,
  output logic                    line_set_dirty_o,
  output logic [TAG_WIDTH-1:0]    line_tag_o,
  output logic [OFFSET_WIDTH-3:0] line_offset_o,
  output logic [31:0]             line_wdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  input  logic [31:0]             mem_rdata_i,
  input  logic                    mem_ack_i
);

  localparam int unsigned CNT_WIDTH = OFFSET_WIDTH - 2;
  localparam int unsigned LINE_SIZE = 2 ** CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]   req_tag_q;
  logic [SET_WIDTH-1:0]   req_idx_q;
  logic [CNT_WIDTH-1:0]   req_off_q;
  logic                   req_we_q;
  logic [31:0]            req_wdata_q;
  logic                   accept;
  logic                   last_beat;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign accept           = (state_q == IDLE) && cpu_req_i;
  assign last_beat        = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_off_q   <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_tag_q   <= cpu_addr_i[31 -: TAG_WIDTH];
        req_idx_q   <= cpu_addr_i[OFFSET_WIDTH +: SET_WIDTH];
        req_off_q   <= cpu_addr_i[OFFSET_WIDTH-1:2];
        req_we_q    <= cpu_we_i;
        req_wdata_q <= cpu_wdata_i;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    cpu_ready_o      = 1'b0;
    cpu_rdata_o      = '0;
    line_write_en_o  = 1'b0;
    line_update_en_o = 1'b0;
    line_set_valid_o = 1'b0;
    line_set_dirty_o = 1'b0;
    line_tag_o       = '0;
    line_offset_o    = '0;
    line_wdata_o     = '0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i) state_d = COMPARE;
      end

      COMPARE: begin
        line_tag_o    = req_tag_q;
        line_offset_o = req_off_q;
        if (line_hit_i) begin
          cpu_ready_o = 1'b1;
          state_d     = IDLE;
          if (req_we_q) begin
            line_write_en_o  = 1'b1;
            line_wdata_o     = req_wdata_q;
            line_update_en_o = 1'b1;
            line_set_valid_o = 1'b1;
            line_set_dirty_o = 1'b1;
          end else begin
            cpu_rdata_o = line_rdata_i;
          end
        end else begin
          cnt_d   = '0;
          state_d = (line_valid_i && line_dirty_i) ? WRITEBACK : REFILL;
        end
      end

      WRITEBACK: begin
        // Presenting the stored tag makes the array report a hit, so the
        // victim words are readable while the request tag differs.
        line_tag_o    = line_tag_i;
        line_offset_o = cnt_q;
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_addr_o    = {line_tag_i, req_idx_q, cnt_q, 2'b00};
        mem_wdata_o   = line_rdata_i;
        if (mem_ack_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end

      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag_q, req_idx_q, cnt_q, 2'b00};
        line_tag_o = req_tag_q;
        if (mem_ack_i) begin
          line_write_en_o = 1'b1;
          line_offset_o   = cnt_q;
          line_wdata_o    = mem_rdata_i;
          cnt_d           = cnt_q + 1'b1;
          if (last_beat) begin
            line_update_en_o = 1'b1;
            line_set_valid_o = 1'b1;
            line_set_dirty_o = 1'b0;
            cnt_d            = '0;
            state_d          = COMPARE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: models the line array, backing memory and the
// architectural memory view, and checks each transaction cycle by cycle.
module tb_cache_ctrl;

  localparam logic [7:0] IDX = 8'h23;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic        cpu_ready_o;
  logic [31:0] cpu_rdata_o;
  logic        line_hit_i;
  logic        line_valid_i;
  logic        line_dirty_i;
  logic [19:0] line_tag_i;
  logic [31:0] line_rdata_i;
  logic        line_write_en_o;
  logic        line_update_en_o;
  logic        line_set_valid_o;
  logic        line_set_dirty_o;
  logic [19:0] line_tag_o;
  logic [1:0]  line_offset_o;
  logic [31:0] line_wdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cache_ctrl #(.TAG_WIDTH(20), .SET_WIDTH(8), .OFFSET_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
    .line_hit_i(line_hit_i), .line_valid_i(line_valid_i), .line_dirty_i(line_dirty_i),
    .line_tag_i(line_tag_i), .line_rdata_i(line_rdata_i),
    .line_write_en_o(line_write_en_o), .line_update_en_o(line_update_en_o),
    .line_set_valid_o(line_set_valid_o), .line_set_dirty_o(line_set_dirty_o),
    .line_tag_o(line_tag_o), .line_offset_o(line_offset_o), .line_wdata_o(line_wdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Line array model: not cleared by reset
  logic        lv = 1'b0;
  logic        ld = 1'b0;
  logic [19:0] ltag = '0;
  logic [31:0] ldata [4] = '{default: '0};

  assign line_valid_i = lv;
  assign line_dirty_i = ld;
  assign line_tag_i   = ltag;
  assign line_hit_i   = lv && (ltag == line_tag_o);
  assign line_rdata_i = line_hit_i ? ldata[line_offset_o] : '0;

  always @(posedge clk_i) begin
    if (line_write_en_o) ldata[line_offset_o] <= line_wdata_o;
    if (line_update_en_o) begin
      lv   <= line_set_valid_o;
      ld   <= line_set_dirty_o;
      ltag <= line_tag_o;
    end
  end

  // Backing memory and the architectural view a CPU should observe
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : (a ^ 32'h5A5A_0000);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"},   32'(cpu_ready_o),      32'd0);
    chk({tag, "_rdata"},   cpu_rdata_o,           32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req_o),        32'd0);
    chk({tag, "_mem_we"},  32'(mem_we_o),         32'd0);
    chk({tag, "_addr"},    mem_addr_o,            32'd0);
    chk({tag, "_wr_en"},   32'(line_write_en_o),  32'd0);
    chk({tag, "_upd_en"},  32'(line_update_en_o), 32'd0);
  endtask

  // One CPU transaction. stall_beat: beat index at which ack is withheld
  // 5 cycles (-1 none). abort_beat: after that many write-back acks, reset.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input int ack_pct, input int stall_beat, input int abort_beat);
    logic [19:0] tg;
    logic [1:0]  off;
    logic        hit, was_dirty, ack, is_wb;
    beat_t       q[$];
    int          cyc, acks, stall;
    bit          first, done;
    tg  = addr[31:12];
    off = addr[3:2];
    hit = lv && (ltag == tg);
    was_dirty = hit && ld;
    if (!hit && lv && ld)
      for (int i = 0; i < 4; i++) q.push_back('{1'b1, {ltag, IDX, 2'(i), 2'b00}, ldata[i]});
    if (!hit)
      for (int i = 0; i < 4; i++) q.push_back('{1'b0, {tg, IDX, 2'(i), 2'b00}, 32'd0});

    @(negedge clk_i);
    #1;
    chk("idle_ready", 32'(cpu_ready_o), 32'd0);
    chk("idle_mem_req", 32'(mem_req_o), 32'd0);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    cyc = 0; acks = 0; stall = 0; first = 1'b1; done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      cyc++;
      if (cyc > 300) begin
        chk("timeout", 32'(cyc), 32'd300);
        cpu_req_i = 1'b0; mem_ack_i = 1'b0;
        return;
      end
      if (q.size() > 0 && !first) begin
        if (acks == stall_beat && stall < 5) begin
          ack = 1'b0; stall++;
        end else begin
          ack = ($urandom_range(99) < ack_pct);
        end
        is_wb       = q[0].we;
        mem_ack_i   = ack;
        mem_rdata_i = is_wb ? $urandom : mem_rd(q[0].a);
        cpu_req_i   = 1'($urandom_range(1));
        #1;
        chk("mem_req", 32'(mem_req_o), 32'd1);
        chk("mem_we", 32'(mem_we_o), 32'(is_wb));
        chk("mem_addr", mem_addr_o, q[0].a);
        chk("ready_busy", 32'(cpu_ready_o), 32'd0);
        chk("wr_en", 32'(line_write_en_o), 32'(ack && !is_wb));
        if (is_wb) chk("wb_data", mem_wdata_o, q[0].d);
        else if (ack) chk("refill_wdata", line_wdata_o, mem_rdata_i);
        if (ack) begin
          if (is_wb) mem[q[0].a] = q[0].d;
          void'(q.pop_front());
          acks++;
        end
        if (abort_beat >= 0 && is_wb && acks == abort_beat) begin
          @(negedge clk_i);
          mem_ack_i = 1'b0; cpu_req_i = 1'b0;
          rst_i = 1'b1;
          #1;
          chk_quiet("rst_mid_wb");
          @(negedge clk_i);
          rst_i = 1'b0;
          return;
        end
      end else begin
        mem_ack_i = 1'b0;
        cpu_req_i = 1'b1;
        #1;
        chk("cmp_mem_req", 32'(mem_req_o), 32'd0);
        if (first && !hit) begin
          chk("miss_ready", 32'(cpu_ready_o), 32'd0);
        end else begin
          chk("ready", 32'(cpu_ready_o), 32'd1);
          if (!we) chk("rdata", cpu_rdata_o, gold_rd(addr));
          cpu_req_i = 1'b0;
          done = 1'b1;
        end
        first = 1'b0;
      end
    end
    if (we) gold[addr] = wd;

    @(posedge clk_i);
    #1;
    chk("line_valid", 32'(lv), 32'd1);
    chk("line_tag", 32'(ltag), 32'(tg));
    chk("line_dirty", 32'(ld), 32'(we || was_dirty));
    for (int i = 0; i < 4; i++)
      chk("line_word", ldata[i], gold_rd({tg, IDX, 2'(i), 2'b00}));
  endtask

  initial begin
    logic [19:0] tags [4];
    tags = '{20'h00001, 20'h00100, 20'h00200, 20'h00300};

    #2 rst_i = 1'b1;
    #2 chk_quiet("reset");
    @(negedge clk_i);
    #1 chk_quiet("reset_held");
    rst_i = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem[32'h0000_1230 + 32'(4 * i)]  = 32'h0000_00A0 + 32'(i);
      gold[32'h0000_1230 + 32'(4 * i)] = 32'h0000_00A0 + 32'(i);
    end

    // Clean miss, refill A0..A3, load word 1
    txn(1'b0, 32'h0000_1234, 32'd0, 100, -1, -1);
    // Hit store marks line dirty
    txn(1'b1, 32'h0000_1238, 32'hDEAD_BEEF, 100, -1, -1);
    chk("store_word2", ldata[2], 32'hDEAD_BEEF);
    // Conflict load: dirty write-back then refill
    txn(1'b0, 32'h0010_1230, 32'd0, 100, -1, -1);
    chk("wb_mem_word2", mem_rd(32'h0000_1238), 32'hDEAD_BEEF);
    // Stalled refill, store into new tag
    txn(1'b1, 32'h0020_123C, 32'h1357_9BDF, 100, 2, -1);
    // Reset after two write-back beats, then redo the same request
    txn(1'b0, 32'h0030_1234, 32'd0, 100, -1, 2);
    txn(1'b0, 32'h0030_1234, 32'd0, 100, -1, -1);
    chk("post_reset_wb", mem_rd(32'h0020_123C), 32'h1357_9BDF);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(3)], IDX, 2'($urandom_range(3)), 2'b00};
      txn(1'($urandom_range(1)), a, $urandom, 60,
          ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
